// File: rtl/cam_cache_ctrl.sv
// CAM cache sequencer: round-robin arbiter, lookup FSM and miss-fill engine for NREQ requesters.
// Define CAM_CTRL_STATS_EN to add saturating hit/miss/bypass counters.
module cam_cache_ctrl #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned BITS   = 8,
  parameter int unsigned TAG_SZ = 8,
  parameter int unsigned WORDS  = 8,
  parameter int unsigned ID_W   = $clog2(NREQ),
  parameter int unsigned ADDR_W = $clog2(WORDS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ*TAG_SZ-1:0] req_tag_i,
  output logic [NREQ-1:0]        gnt_o,
  output logic                   resp_valid_o,
  output logic [ID_W-1:0]        resp_id_o,
  output logic [BITS-1:0]        resp_data_o,
  output logic                   resp_hit_o,
  output logic                   resp_alloc_o,
  output logic                   cam_read_o,
  output logic [TAG_SZ-1:0]      cam_check_tag_o,
  input  logic                   cam_found_it_i,
  input  logic [BITS-1:0]        cam_data_i,
  input  logic                   cam_full_i,
  output logic                   cam_write_n_o,
  output logic                   cam_new_valid_o,
  output logic [TAG_SZ-1:0]      cam_new_tag_o,
  output logic [BITS-1:0]        cam_wdata_o,
  output logic [ADDR_W-1:0]      cam_w_addr_o,
  output logic                   mem_req_o,
  output logic [TAG_SZ-1:0]      mem_tag_o,
  input  logic                   mem_ack_i,
  input  logic [BITS-1:0]        mem_rdata_i
`ifdef CAM_CTRL_STATS_EN
  ,
  output logic [15:0]            stat_hits_o,
  output logic [15:0]            stat_misses_o,
  output logic [15:0]            stat_bypass_o
`endif
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLookup = 3'd1;
  localparam logic [2:0] StMem    = 3'd2;
  localparam logic [2:0] StFill   = 3'd3;
  localparam logic [2:0] StResp   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [TAG_SZ-1:0] tag_q, tag_d;
  logic [BITS-1:0]   data_q, data_d;
  logic              hit_q, hit_d;
  logic              full_q, full_d;
  logic              alloc_q, alloc_d;

  logic              any_req;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   idx;

  // First requester at or after the round-robin pointer wins; grants only in idle.
  always_comb begin
    any_req = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    gnt_o   = '0;
    if (state_q == StIdle) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = ID_W'((32'(rr_q) + k) % NREQ);
        if (!any_req && req_i[idx]) begin
          any_req = 1'b1;
          gnt_id  = idx;
        end
      end
      gnt_o[gnt_id] = any_req;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    tag_d   = tag_q;
    data_d  = data_q;
    hit_d   = hit_q;
    full_d  = full_q;
    alloc_d = alloc_q;
    case (state_q)
      StIdle: begin
        if (any_req) begin
          tag_d   = req_tag_i[gnt_id*TAG_SZ +: TAG_SZ];
          id_d    = gnt_id;
          rr_d    = ID_W'((32'(gnt_id) + 1) % NREQ);
          state_d = StLookup;
        end
      end
      StLookup: begin
        hit_d   = cam_found_it_i;
        full_d  = cam_full_i;
        alloc_d = 1'b0;
        if (cam_found_it_i) begin
          data_d  = cam_data_i;
          state_d = StResp;
        end else begin
          state_d = StMem;
        end
      end
      StMem: begin
        if (mem_ack_i) begin
          data_d  = mem_rdata_i;
          alloc_d = ~full_q;
          state_d = full_q ? StResp : StFill;
        end
      end
      StFill:  state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      rr_q    <= '0;
      id_q    <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      hit_q   <= 1'b0;
      full_q  <= 1'b0;
      alloc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      hit_q   <= hit_d;
      full_q  <= full_d;
      alloc_q <= alloc_d;
    end
  end

  // Strobes decode straight from state so an async reset clears them without a clock.
  assign resp_valid_o    = (state_q == StResp);
  assign resp_id_o       = id_q;
  assign resp_data_o     = data_q;
  assign resp_hit_o      = hit_q;
  assign resp_alloc_o    = alloc_q;
  assign cam_read_o      = (state_q == StLookup);
  assign cam_check_tag_o = tag_q;
  assign cam_write_n_o   = (state_q != StFill);
  assign cam_new_valid_o = (state_q == StFill);
  assign cam_new_tag_o   = tag_q;
  assign cam_wdata_o     = data_q;
  assign cam_w_addr_o    = '0;
  assign mem_req_o       = (state_q == StMem);
  assign mem_tag_o       = tag_q;

`ifdef CAM_CTRL_STATS_EN
  logic [15:0] hits_q, misses_q, bypass_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hits_q   <= '0;
      misses_q <= '0;
      bypass_q <= '0;
    end else if (state_q == StResp) begin
      if (hit_q) begin
        if (hits_q != 16'hFFFF) hits_q <= hits_q + 16'd1;
      end else begin
        if (misses_q != 16'hFFFF) misses_q <= misses_q + 16'd1;
        if (!alloc_q && bypass_q != 16'hFFFF) bypass_q <= bypass_q + 16'd1;
      end
    end
  end

  assign stat_hits_o   = hits_q;
  assign stat_misses_o = misses_q;
  assign stat_bypass_o = bypass_q;
`endif

endmodule

// File: tb/tb_cam_cache_ctrl.sv
// Directed bench for cam_cache_ctrl with a behavioural 8-entry CAM and a zero-wait backing memory.
module tb_cam_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [15:0] req_tag;
  logic [1:0]  gnt;
  logic        resp_valid;
  logic [0:0]  resp_id;
  logic [7:0]  resp_data;
  logic        resp_hit;
  logic        resp_alloc;
  logic        cam_read;
  logic [7:0]  cam_check_tag;
  logic        cam_found_it;
  logic [7:0]  cam_data;
  logic        cam_full;
  logic        cam_write_n;
  logic        cam_new_valid;
  logic [7:0]  cam_new_tag;
  logic [7:0]  cam_wdata;
  logic [2:0]  cam_w_addr;
  logic        mem_req;
  logic [7:0]  mem_tag;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cam_cache_ctrl dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_i           (req),
    .req_tag_i       (req_tag),
    .gnt_o           (gnt),
    .resp_valid_o    (resp_valid),
    .resp_id_o       (resp_id),
    .resp_data_o     (resp_data),
    .resp_hit_o      (resp_hit),
    .resp_alloc_o    (resp_alloc),
    .cam_read_o      (cam_read),
    .cam_check_tag_o (cam_check_tag),
    .cam_found_it_i  (cam_found_it),
    .cam_data_i      (cam_data),
    .cam_full_i      (cam_full),
    .cam_write_n_o   (cam_write_n),
    .cam_new_valid_o (cam_new_valid),
    .cam_new_tag_o   (cam_new_tag),
    .cam_wdata_o     (cam_wdata),
    .cam_w_addr_o    (cam_w_addr),
    .mem_req_o       (mem_req),
    .mem_tag_o       (mem_tag),
    .mem_ack_i       (mem_ack),
    .mem_rdata_i     (mem_rdata)
  );

  // Behavioural CAM: fills the lowest invalid slot.
  logic [7:0] cval = '0;
  logic [7:0] ctag [8];
  logic [7:0] cdata [8];
  logic [2:0] free_idx;
  int         writes = 0;
  logic [7:0] last_wtag = '0;
  logic [7:0] last_wdata = '0;

  always_comb begin
    cam_found_it = 1'b0;
    cam_data     = '0;
    cam_full     = 1'b1;
    free_idx     = '0;
    for (int i = 7; i >= 0; i--) begin
      if (cval[i] && ctag[i] == cam_check_tag) begin
        cam_found_it = 1'b1;
        cam_data     = cdata[i];
      end
      if (!cval[i]) begin
        cam_full = 1'b0;
        free_idx = 3'(i);
      end
    end
  end

  always @(posedge clk) begin
    if (!cam_write_n) begin
      writes     <= writes + 1;
      last_wtag  <= cam_new_tag;
      last_wdata <= cam_wdata;
      if (cam_new_valid && !cam_full) begin
        cval[free_idx]  <= 1'b1;
        ctag[free_idx]  <= cam_new_tag;
        cdata[free_idx] <= cam_wdata;
      end
    end
  end

  // Backing memory answers in the first MEM cycle when enabled.
  logic ack_en = 1'b1;
  logic ack_stuck = 1'b0;

  function automatic logic [7:0] mem_fn(input logic [7:0] t);
    case (t)
      8'h3C:   return 8'hA5;
      8'h99:   return 8'h77;
      default: return t ^ 8'h5A;
    endcase
  endfunction

  assign mem_ack   = (ack_en && mem_req) || ack_stuck;
  assign mem_rdata = mem_fn(mem_tag);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(output int waited);
    bit got = 1'b0;
    waited = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (gnt != 2'b00) got = 1'b1;
      else begin
        @(posedge clk); #1;
        waited++;
      end
    end
  endtask

  // One transaction from requester id; entered and left at posedge+1 with the DUT idle.
  task automatic txn(input int id, input logic [7:0] tag, input bit exp_hit, input bit exp_alloc,
                     input logic [7:0] exp_data, input int exp_lat, input string nm);
    int         cyc;
    int         waited;
    int         wr0;
    bit         saw_mem;
    logic [1:0] exp_g;
    exp_g = 2'b01 << id;
    req[id] = 1'b1;
    req_tag[id*8 +: 8] = tag;
    #1;
    wait_gnt(waited);
    check({nm, "_gnt"}, 32'(gnt), 32'(exp_g));
    wr0 = writes;
    @(posedge clk); #1;
    req[id] = 1'b0;
    cyc = 1;
    saw_mem = 1'b0;
    while (!resp_valid && cyc < 40) begin
      if (mem_req) saw_mem = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    check({nm, "_lat"}, 32'(cyc), 32'(exp_lat));
    check({nm, "_id"}, 32'(resp_id), 32'(id));
    check({nm, "_data"}, 32'(resp_data), 32'(exp_data));
    check({nm, "_hit"}, 32'(resp_hit), 32'(exp_hit));
    check({nm, "_memreq"}, 32'(saw_mem), 32'(!exp_hit));
    check({nm, "_writes"}, 32'(writes - wr0), (!exp_hit && exp_alloc) ? 32'd1 : 32'd0);
    if (!exp_hit) check({nm, "_alloc"}, 32'(resp_alloc), 32'(exp_alloc));
    @(posedge clk); #1;
    check({nm, "_onecycle"}, 32'(resp_valid), 32'd0);
  endtask

  logic [1:0] exp_order [4];
  int         waited;
  int         wr_before;

  initial begin
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst_n   = 1'b0;
    req     = '0;
    req_tag = '0;
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_cam_write_n", 32'(cam_write_n), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_cam_read", 32'(cam_read), 32'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // Cold miss with fill, then a hit on the same tag from the other requester.
    txn(0, 8'h3C, 1'b0, 1'b1, 8'hA5, 4, "miss_fill");
    check("fill_tag", 32'(last_wtag), 32'h3C);
    check("fill_data", 32'(last_wdata), 32'hA5);
    txn(1, 8'h3C, 1'b1, 1'b0, 8'hA5, 2, "hit");

    // Both requesters held: alternating grants with a single idle cycle between them.
    req_tag = {8'h11, 8'h10};
    req     = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(waited);
      check("rr_gnt", 32'(gnt), 32'(exp_order[k]));
      if (k > 0) check("rr_b2b_wait", 32'(waited), 32'd0);
      @(posedge clk); #1;
      case (k)
        0:       req_tag[7:0] = 8'h12;
        1:       req_tag[15:8] = 8'h13;
        2:       req[0] = 1'b0;
        default: req[1] = 1'b0;
      endcase
      for (int i = 0; i < 40 && !resp_valid; i++) begin
        check("rr_no_gnt_busy", 32'(gnt), 32'd0);
        @(posedge clk); #1;
      end
      check("rr_resp", 32'(resp_valid), 32'd1);
      check("rr_resp_id", 32'(resp_id), 32'(k % 2));
      @(posedge clk); #1;
    end

    // Fill the remaining three slots, then a miss must bypass the full CAM.
    txn(0, 8'h20, 1'b0, 1'b1, 8'h20 ^ 8'h5A, 4, "fill6");
    txn(0, 8'h21, 1'b0, 1'b1, 8'h21 ^ 8'h5A, 4, "fill7");
    txn(0, 8'h22, 1'b0, 1'b1, 8'h22 ^ 8'h5A, 4, "fill8");
    txn(0, 8'h99, 1'b0, 1'b0, 8'h77, 3, "bypass");
    txn(1, 8'h99, 1'b0, 1'b0, 8'h77, 3, "bypass_again");
    txn(0, 8'h12, 1'b1, 1'b0, 8'h12 ^ 8'h5A, 2, "hit_rr_tag");

    // A stuck mem_ack outside MEM must not disturb a hit.
    ack_stuck = 1'b1;
    txn(1, 8'h3C, 1'b1, 1'b0, 8'hA5, 2, "ack_outside_mem");
    ack_stuck = 1'b0;

    // Async reset while waiting on memory.
    ack_en = 1'b0;
    wr_before = writes;
    req[0] = 1'b1;
    req_tag[7:0] = 8'h66;
    #1;
    wait_gnt(waited);
    @(posedge clk); #1;
    req[0] = 1'b0;
    for (int i = 0; i < 5 && !mem_req; i++) begin
      @(posedge clk); #1;
    end
    check("mid_mem_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_req", 32'(mem_req), 32'd0);
    check("arst_cam_write_n", 32'(cam_write_n), 32'd1);
    check("arst_resp_valid", 32'(resp_valid), 32'd0);
    check("arst_resp_data", 32'(resp_data), 32'd0);
    check("arst_check_tag", 32'(cam_check_tag), 32'd0);
    @(posedge clk); #1;
    check("arst_no_resp", 32'(resp_valid), 32'd0);
    #1 rst_n = 1'b1;
    ack_en = 1'b1;
    @(posedge clk); #1;
    check("arst_no_write", 32'(writes - wr_before), 32'd0);
    txn(0, 8'h3C, 1'b1, 1'b0, 8'hA5, 2, "post_rst_hit");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
